// File: rtl/seq_codes_enc_onehot_stream_if.sv
// Stream bundle for the one-hot encoder: code input side, binary result side,
// and the error-counter controls.
interface seq_codes_enc_onehot_stream_if #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned CNTW  = 4
);
    localparam int unsigned OW = $clog2(NBITS);

    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_;
    logic             mode;
    logic             out_val;
    logic             out_rdy;
    logic [OW-1:0]    out;
    logic             out_err;
    logic             err_clear;
    logic [CNTW-1:0]  err_count;

    modport master (
        output in_val, in_, mode, out_rdy, err_clear,
        input  in_rdy, out_val, out, out_err, err_count
    );

    modport slave (
        input  in_val, in_, mode, out_rdy, err_clear,
        output in_rdy, out_val, out, out_err, err_count
    );
endinterface

// File: rtl/seq_codes_enc_onehot_stream.sv
// Registered one-hot-to-binary encoder with valid/ready handshake, strict or
// priority decoding, and a saturating count of invalid codes.
module seq_codes_enc_onehot_stream #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned CNTW  = 4
) (
    input logic                          clk,
    input logic                          reset,
    seq_codes_enc_onehot_stream_if.slave bus
);
    localparam int unsigned OW = $clog2(NBITS);

    logic [OW-1:0]   low_idx;
    logic            is_zero;
    logic            is_onehot;
    logic [OW-1:0]   enc_out;
    logic            enc_err;
    logic            accept;

    logic            out_val_q, out_val_d;
    logic [OW-1:0]   out_q, out_d;
    logic            out_err_q, out_err_d;
    logic [CNTW-1:0] err_count_q, err_count_d;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = NBITS; i > 0; i--) begin
            if (bus.in_[i-1]) low_idx = OW'(i - 1);
        end
    end

    assign is_zero   = (bus.in_ == '0);
    assign is_onehot = !is_zero && ((bus.in_ & (bus.in_ - NBITS'(1))) == '0);

    always_comb begin
        enc_err = bus.mode ? is_zero : !is_onehot;
        enc_out = enc_err ? '0 : low_idx;
    end

    assign bus.in_rdy = !out_val_q || bus.out_rdy;
    assign accept     = bus.in_val && bus.in_rdy;

    always_comb begin
        out_val_d   = out_val_q;
        out_d       = out_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;

        if (accept) begin
            out_val_d = 1'b1;
            out_d     = enc_out;
            out_err_d = enc_err;
        end else if (bus.out_rdy) begin
            out_val_d = 1'b0;
        end

        if (bus.err_clear) begin
            err_count_d = '0;
        end else if (accept && enc_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val_q   <= 1'b0;
            out_q       <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_val_q   <= out_val_d;
            out_q       <= out_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_val   = out_val_q;
    assign bus.out       = out_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_seq_codes_enc_onehot_stream.sv
// Bench for seq_codes_enc_onehot_stream: directed scenarios plus a random run
// compared against a bit-arithmetic reference of the encoder and handshake.
module tb_seq_codes_enc_onehot_stream;
    localparam int unsigned NBITS = 8;
    localparam int unsigned CNTW  = 4;
    localparam int unsigned OW    = $clog2(NBITS);
    localparam int unsigned MAXC  = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_codes_enc_onehot_stream_if #(.NBITS(NBITS), .CNTW(CNTW)) bus ();

    seq_codes_enc_onehot_stream #(.NBITS(NBITS), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference encoding: isolate the lowest set bit arithmetically.
    function automatic int unsigned lsb_of(logic [NBITS-1:0] c);
        int unsigned v;
        v = c;
        return v & (~v + 1);
    endfunction

    function automatic logic ref_err(logic [NBITS-1:0] c, logic m);
        if (c == 0) return 1'b1;
        if (!m && (lsb_of(c) != c)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [OW-1:0] ref_out(logic [NBITS-1:0] c, logic m);
        if (ref_err(c, m)) return '0;
        return OW'($clog2(lsb_of(c)));
    endfunction

    logic          m_val;
    logic [OW-1:0] m_out;
    logic          m_err;
    int unsigned   m_cnt;
    logic          m_acc;

    assign m_acc = bus.in_val && (!m_val || bus.out_rdy);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_val <= 1'b0;
            m_out <= '0;
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (m_acc) begin
                m_val <= 1'b1;
                m_out <= ref_out(bus.in_, bus.mode);
                m_err <= ref_err(bus.in_, bus.mode);
            end else if (bus.out_rdy) begin
                m_val <= 1'b0;
            end
            if (bus.err_clear) m_cnt <= 0;
            else if (m_acc && ref_err(bus.in_, bus.mode) && m_cnt < MAXC) m_cnt <= m_cnt + 1;
        end
    end

    task automatic drive(input logic v, input logic [NBITS-1:0] c, input logic m,
                         input logic ordy, input logic clr);
        bus.in_val    = v;
        bus.in_       = c;
        bus.mode      = m;
        bus.out_rdy   = ordy;
        bus.err_clear = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL rst_out_val got %0b exp 0", bus.out_val); end
        checks++; if (bus.out !== '0) begin errors++; $display("FAIL rst_out got %0d exp 0", bus.out); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %0b exp 0", bus.out_err); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", bus.err_count); end
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy got %0b exp 1", bus.in_rdy); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %0b exp 0", bus.out_val); end
    endtask

    task automatic test_valid_codes;
        logic [NBITS-1:0] codes [3] = '{8'h01, 8'h04, 8'h80};
        int unsigned      exp   [3] = '{0, 2, 7};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, codes[i], 1'b0, 1'b1, 1'b0);
            tick();
            checks++; if (bus.out_val !== 1'b1 || bus.out !== OW'(exp[i]) || bus.out_err !== 1'b0)
                begin errors++; $display("FAIL valid_code%0d got val=%0b out=%0d err=%0b exp val=1 out=%0d err=0", i, bus.out_val, bus.out, bus.out_err, exp[i]); end
            checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL valid_cnt%0d got %0d exp 0", i, bus.err_count); end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out_val !== 1'b0 || bus.out !== OW'(7))
            begin errors++; $display("FAIL drain_hold got val=%0b out=%0d exp val=0 out=7", bus.out_val, bus.out); end
    endtask

    task automatic test_invalid_priority;
        drive(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out !== '0 || bus.out_err !== 1'b1 || bus.err_count !== CNTW'(1))
            begin errors++; $display("FAIL strict_30 got out=%0d err=%0b cnt=%0d exp 0 1 1", bus.out, bus.out_err, bus.err_count); end
        drive(1'b1, 8'h30, 1'b1, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out !== OW'(4) || bus.out_err !== 1'b0 || bus.err_count !== CNTW'(1))
            begin errors++; $display("FAIL prio_30 got out=%0d err=%0b cnt=%0d exp 4 0 1", bus.out, bus.out_err, bus.err_count); end
        // Later mode/code changes must not disturb the held result.
        drive(1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.out !== OW'(4) || bus.out_err !== 1'b0 || bus.out_val !== 1'b1)
            begin errors++; $display("FAIL sampled_hold got out=%0d err=%0b val=%0b exp 4 0 1", bus.out, bus.out_err, bus.out_val); end
        for (int m = 0; m < 2; m++) begin
            drive(1'b1, 8'h00, m[0], 1'b1, 1'b0);
            tick();
            checks++; if (bus.out !== '0 || bus.out_err !== 1'b1 || bus.err_count !== CNTW'(2 + m))
                begin errors++; $display("FAIL zero_mode%0d got out=%0d err=%0b cnt=%0d exp 0 1 %0d", m, bus.out, bus.out_err, bus.err_count, 2 + m); end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL clear got %0d exp 0", bus.err_count); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        drive(1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out !== OW'(3) || bus.out_val !== 1'b1)
            begin errors++; $display("FAIL bp_first got out=%0d val=%0b exp 3 1", bus.out, bus.out_val); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
            #1;
            checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy%0d got %0b exp 0", i, bus.in_rdy); end
            tick();
            checks++; if (bus.out !== OW'(3) || bus.out_val !== 1'b1 || bus.out_err !== 1'b0)
                begin errors++; $display("FAIL bp_stable%0d got out=%0d val=%0b err=%0b exp 3 1 0", i, bus.out, bus.out_val, bus.out_err); end
        end
        drive(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %0b exp 1", bus.in_rdy); end
        tick();
        checks++; if (bus.out !== OW'(6) || bus.out_val !== 1'b1)
            begin errors++; $display("FAIL bp_accept got out=%0d val=%0b exp 6 1", bus.out, bus.out_val); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_saturation;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
            tick();
            checks++; if (bus.err_count !== CNTW'((i + 1 > MAXC) ? MAXC : i + 1))
                begin errors++; $display("FAIL sat%0d got %0d exp %0d", i, bus.err_count, (i + 1 > MAXC) ? MAXC : i + 1); end
        end
        drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        checks++; if (bus.err_count !== '0 || bus.out_err !== 1'b1)
            begin errors++; $display("FAIL clear_priority got cnt=%0d err=%0b exp 0 1", bus.err_count, bus.out_err); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.out_val !== 1'b1 || bus.out !== OW'(4) || bus.err_count !== CNTW'(1))
            begin errors++; $display("FAIL pre_reset got val=%0b out=%0d cnt=%0d exp 1 4 1", bus.out_val, bus.out, bus.err_count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.out_val !== 1'b0 || bus.out !== '0 || bus.out_err !== 1'b0 || bus.err_count !== '0)
            begin errors++; $display("FAIL async_reset got val=%0b out=%0d err=%0b cnt=%0d exp all 0", bus.out_val, bus.out, bus.out_err, bus.err_count); end
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL async_reset_rdy got %0b exp 1", bus.in_rdy); end
        #1;
        reset = 1'b1;
        drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out_val !== 1'b1 || bus.out !== OW'(1) || bus.out_err !== 1'b0)
            begin errors++; $display("FAIL after_reset got val=%0b out=%0d err=%0b exp 1 1 0", bus.out_val, bus.out, bus.out_err); end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back;
        int unsigned k;
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(NBITS - 1, 0);
            drive(1'b1, NBITS'(1) << k, $urandom_range(1, 0), 1'b1, 1'b0);
            #1;
            checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got %0b exp 1", i, bus.in_rdy); end
            tick();
            checks++; if (bus.out_val !== 1'b1 || bus.out !== OW'(k) || bus.out_err !== 1'b0)
                begin errors++; $display("FAIL b2b%0d got val=%0b out=%0d err=%0b exp 1 %0d 0", i, bus.out_val, bus.out, bus.out_err, k); end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random;
        logic [NBITS-1:0] c;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(2, 0))
                0:       c = '0;
                1:       c = NBITS'(1) << $urandom_range(NBITS - 1, 0);
                default: c = NBITS'($urandom);
            endcase
            drive($urandom_range(3, 0) != 0, c, $urandom_range(1, 0),
                  $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
            #1;
            checks++; if (bus.in_rdy !== (!m_val || bus.out_rdy))
                begin errors++; $display("FAIL rnd_rdy%0d got %0b exp %0b", i, bus.in_rdy, !m_val || bus.out_rdy); end
            tick();
            checks++; if (bus.out_val !== m_val || bus.out !== m_out || bus.out_err !== m_err || bus.err_count !== CNTW'(m_cnt))
                begin errors++; $display("FAIL rnd%0d got val=%0b out=%0d err=%0b cnt=%0d exp %0b %0d %0b %0d",
                    i, bus.out_val, bus.out, bus.out_err, bus.err_count, m_val, m_out, m_err, m_cnt); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_valid_codes();
        test_invalid_priority();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
